// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - field-level instruction encoder and sequential instruction-memory loader
// Packs op/reg/imm fields into 16-bit words and writes them from address 0 while holding the CPU in reset.
module instr_encoder_loader #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [2:0]        in_ra,
  input  logic [2:0]        in_rb,
  input  logic [2:0]        in_rd,
  input  logic [11:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [15:0]       r_wdata;
  logic              r_last;
  logic              r_err;
  logic [1:0]        r_err_code;
  logic [15:0]       w_enc;
  logic [1:0]        w_enc_err;
  logic              w_hs;
  logic              w_imm_ok;

  assign w_hs     = in_valid & in_ready;
  // Short immediates must sign-extend from bit 5: bits 11..5 all equal.
  assign w_imm_ok = (&in_imm[11:5]) | ~(|in_imm[11:5]);

  always_comb begin
    w_enc     = '0;
    w_enc_err = 2'b00;
    case (in_op)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9:
        w_enc = {in_op, in_ra, in_rb, in_rd, 3'b000};
      4'h0, 4'h1, 4'hB, 4'hC: begin
        w_enc = {in_op, in_ra, in_rb, in_imm[5:0]};
        if (!w_imm_ok) w_enc_err = 2'b10;
      end
      4'hD:
        w_enc = {in_op, in_imm};
      default:
        w_enc_err = 2'b01;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    imem_we  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ACCEPT;
      end
      S_ACCEPT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_hs) w_next = (w_enc_err != 2'b00) ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        // Gated by reset so a reset landing on the write cycle suppresses the store.
        imem_we = reset_n;
        busy    = 1'b1;
        if (r_last || r_addr == LAST_ADDR) w_next = S_DONE;
        else                               w_next = S_ACCEPT;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_count    <= '0;
      r_wdata    <= '0;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr     <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
          end
        end
        S_ACCEPT: begin
          if (w_hs) begin
            if (w_enc_err != 2'b00) begin
              r_err      <= 1'b1;
              r_err_code <= w_enc_err;
            end else begin
              r_wdata <= w_enc;
              r_last  <= in_last;
            end
          end
        end
        S_WRITE: begin
          r_count <= r_count + 1'b1;
          // Address saturates at the top word; running out of room is an error unless last.
          if (r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
          if (!r_last && r_addr == LAST_ADDR) begin
            r_err      <= 1'b1;
            r_err_code <= 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = busy;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign word_count = r_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - scoreboard bench for instr_encoder_loader
// Directed sessions plus random sessions checked against a field-level encoding model.
module tb_instr_encoder_loader;

  typedef struct packed {
    logic        last;
    logic [3:0]  op;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  rd;
    logic [11:0] imm;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [2:0]  in_ra = '0;
  logic [2:0]  in_rb = '0;
  logic [2:0]  in_rd = '0;
  logic [11:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [4:0]  word_count;

  instr_encoder_loader #(.ADDR_W(4), .DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int done_seen = 0;
  int done_target = 0;
  logic [19:0] wq[$];
  logic [7:0]  dq[$];
  instr_t      sess_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoding from the field rules, using plain integer arithmetic.
  function automatic void model_encode(input instr_t t, output int word, output int code);
    int op;
    int s;
    op = int'(t.op);
    s = int'($signed(t.imm));
    word = 0;
    code = 0;
    if (op >= 2 && op <= 9)
      word = op * 4096 + int'(t.ra) * 512 + int'(t.rb) * 64 + int'(t.rd) * 8;
    else if (op == 0 || op == 1 || op == 11 || op == 12) begin
      if (s < -32 || s > 31) code = 2;
      else word = op * 4096 + int'(t.ra) * 512 + int'(t.rb) * 64 + (s & 63);
    end else if (op == 13)
      word = op * 4096 + int'(t.imm);
    else
      code = 1;
  endfunction

  always @(negedge clk) begin
    logic [19:0] ew;
    logic [7:0]  ed;
    if (imem_we) begin
      if (wq.size() == 0) chk("unexpected_write", {12'h0, imem_addr, imem_wdata}, 32'hFFFF_FFFF);
      else begin
        ew = wq.pop_front();
        chk("write_addr", 32'(imem_addr), 32'(ew[19:16]));
        chk("write_data", 32'(imem_wdata), 32'(ew[15:0]));
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("unexpected_done", 32'(done), 32'h0);
      else begin
        ed = dq.pop_front();
        chk("done_err", 32'(err), 32'(ed[7]));
        chk("done_err_code", 32'(err_code), 32'(ed[6:5]));
        chk("done_word_count", 32'(word_count), 32'(ed[4:0]));
        chk("done_cpu_hold", 32'(cpu_hold), 32'h0);
        chk("done_in_ready", 32'(in_ready), 32'h0);
      end
      done_seen++;
    end
  end

  task automatic drive_fields(input instr_t t);
    in_op = t.op; in_ra = t.ra; in_rb = t.rb; in_rd = t.rd; in_imm = t.imm; in_last = t.last;
  endtask

  task automatic send(input instr_t t);
    int n;
    @(negedge clk);
    drive_fields(t);
    in_valid = 1'b1;
    start = 1'($urandom_range(0, 1));
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start = 1'b0;
    in_op = 4'($urandom);
    in_imm = 12'($urandom);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b1;
    in_op = 4'hE;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'h0);
    chk({tag, "_imem_we"}, 32'(imem_we), 32'h0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 32'h0);
    chk({tag, "_imem_wdata"}, 32'(imem_wdata), 32'h0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_err_code"}, 32'(err_code), 32'h0);
    chk({tag, "_word_count"}, 32'(word_count), 32'h0);
  endtask

  // Runs sess_q as one session; the model decides where the session ends.
  task automatic run_session();
    int word, code, n_send, addr, cnt, n;
    bit ended;
    logic [7:0] fin;
    addr = 0; cnt = 0; ended = 0; n_send = 0; fin = '0;
    for (int i = 0; i < sess_q.size() && !ended; i++) begin
      n_send++;
      model_encode(sess_q[i], word, code);
      if (code != 0) begin
        fin = {1'b1, 2'(code), 5'(cnt)};
        ended = 1;
      end else begin
        wq.push_back({4'(addr), 16'(word)});
        cnt++;
        if (sess_q[i].last) begin
          fin = {1'b0, 2'b00, 5'(cnt)};
          ended = 1;
        end else if (addr == 15) begin
          fin = {1'b1, 2'b11, 5'(cnt)};
          ended = 1;
        end else addr++;
      end
    end
    dq.push_back(fin);
    do_start();
    for (int i = 0; i < n_send; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(sess_q[i]);
    end
    done_target++;
    n = 0;
    while (done_seen < done_target && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done_seen < done_target) chk("done_timeout", 32'(done_seen), 32'(done_target));
    repeat (2) begin
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("hold_err", 32'(err), 32'(fin[7]));
      chk("hold_err_code", 32'(err_code), 32'(fin[6:5]));
      chk("hold_word_count", 32'(word_count), 32'(fin[4:0]));
    end
    chk("writes_drained", 32'(wq.size()), 32'h0);
    sess_q.delete();
  endtask

  function automatic instr_t mk(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                                input logic [2:0] rd, input logic [11:0] imm, input logic last);
    instr_t t;
    t.op = op; t.ra = ra; t.rb = rb; t.rd = rd; t.imm = imm; t.last = last;
    return t;
  endfunction

  initial begin
    instr_t t;
    int len;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // T1: single ADD
    sess_q.push_back(mk(4'h2, 3'd1, 3'd2, 3'd3, 12'h0, 1'b1));
    run_session();
    // T2: LW then JMP
    sess_q.push_back(mk(4'h0, 3'd0, 3'd1, 3'd0, 12'hFFE, 1'b0));
    sess_q.push_back(mk(4'hD, 3'd0, 3'd0, 3'd0, 12'h005, 1'b1));
    run_session();
    // T3: illegal opcode
    sess_q.push_back(mk(4'hE, 3'd1, 3'd1, 3'd1, 12'h0, 1'b1));
    run_session();
    // T4: BEQ out of range, then BNE at the negative boundary, then +31 / -33 edges
    sess_q.push_back(mk(4'hB, 3'd1, 3'd2, 3'd0, 12'd40, 1'b1));
    run_session();
    sess_q.push_back(mk(4'hC, 3'd0, 3'd0, 3'd0, 12'hFE0, 1'b0));
    sess_q.push_back(mk(4'h1, 3'd7, 3'd7, 3'd0, 12'd31, 1'b1));
    run_session();
    sess_q.push_back(mk(4'h1, 3'd2, 3'd3, 3'd0, 12'hFDF, 1'b1));
    run_session();
    // T5: memory overflow with 16 non-last ADDs
    for (int i = 0; i < 17; i++) sess_q.push_back(mk(4'h2, 3'(i), 3'(i + 1), 3'(i + 2), 12'h0, 1'b0));
    run_session();

    // T6: reset on the write cycle of the third instruction
    wq.push_back({4'd0, 16'h2000});
    wq.push_back({4'd1, 16'h2000});
    do_start();
    send(mk(4'h2, 3'd0, 3'd0, 3'd0, 12'h0, 1'b0));
    send(mk(4'h2, 3'd0, 3'd0, 3'd0, 12'h0, 1'b0));
    send(mk(4'h2, 3'd0, 3'd0, 3'd0, 12'h0, 1'b0));
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    chk("midreset_writes", 32'(wq.size()), 32'h0);
    sess_q.push_back(mk(4'h9, 3'd5, 3'd6, 3'd7, 12'h0, 1'b1));
    run_session();

    // Random sessions
    for (int s = 0; s < 40; s++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        t.op = 4'($urandom);
        t.ra = 3'($urandom);
        t.rb = 3'($urandom);
        t.rd = 3'($urandom);
        t.imm = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 80)) - 12'd40 : 12'($urandom);
        t.last = (i == len - 1) || ($urandom_range(0, 5) == 0);
        sess_q.push_back(t);
      end
      run_session();
    end

    chk("done_drained", 32'(dq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
